// File: rtl/arb_pkg.sv
// Shared types for the 4-way round-robin index arbiter.
// Holds the FSM state enum, requester count and grant index type.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    typedef logic [1:0] idx_t;

endpackage

// File: rtl/rr_pick4.sv
// Rotated priority search over four requests, starting at ptr.
// Ports: req, ptr in; any (some request set), win_idx (winner) out.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  idx_t               ptr,
    output logic               any,
    output idx_t               win_idx
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    idx_t                 off;

    // rot[i] is req[(ptr+i) mod 4], so bit 0 has top priority
    assign dbl = {req, req};
    assign rot = dbl[ptr +: NUM_REQ];
    assign any = |req;

    always_comb begin
        off = 2'd0;
        priority case (1'b1)
            rot[0]:  off = 2'd0;
            rot[1]:  off = 2'd1;
            rot[2]:  off = 2'd2;
            rot[3]:  off = 2'd3;
            default: off = 2'd0;
        endcase
    end

    // 2-bit add wraps 3->0
    assign win_idx = ptr + off;

endmodule

// File: rtl/rr_arb4_idx.sv
// Round-robin arbiter: registered grant index/valid with hold limit.
// Ports: clk, reset, req[3:0], done in; gnt_idx, gnt_valid, timeout out.
module rr_arb4_idx
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output idx_t               gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    arb_state_t       state;
    idx_t             ptr;
    logic [CNT_W-1:0] hold_cnt;

    logic any;
    idx_t win_idx;
    logic own_req;
    logic at_lim;
    logic rel;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr),
        .any     (any),
        .win_idx (win_idx)
    );

    assign own_req = req[gnt_idx];
    assign at_lim  = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    assign rel     = done | ~own_req | at_lim;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            gnt_idx   <= 2'd0;
            timeout   <= 1'b0;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any) begin
                        state     <= GRANT;
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + 2'd1;
                        hold_cnt  <= '0;
                        // forced release only when nothing else ended it
                        timeout   <= at_lim & ~done & own_req;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb4_idx.sv
// Self-checking bench for rr_arb4_idx with MAX_HOLD=4.
// Table of per-cycle vectors plus a hand-written timeout rotation.
module tb_rr_arb4_idx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       done = 1'b0;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int errs = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic       ev;
        logic [1:0] ei;
        logic       et;
        string      name;
    } vec_t;

    typedef struct {
        logic       ev;
        logic [1:0] ei;
        logic       et;
        string      name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    rr_arb4_idx #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [3:0] q, logic d,
                                logic ev, logic [1:0] ei, logic et,
                                string n);
        vec_t x;
        x.rst = r; x.req = q; x.done = d;
        x.ev = ev; x.ei = ei; x.et = et; x.name = n;
        return x;
    endfunction

    task automatic step(input vec_t x);
        exp_t e;
        @(negedge clk);
        reset = x.rst;
        req   = x.req;
        done  = x.done;
        e.ev = x.ev; e.ei = x.ei; e.et = x.et; e.name = x.name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (gnt_valid !== e.ev || gnt_idx !== e.ei || timeout !== e.et) begin
            errs++;
            $display("FAIL %s: got v=%b i=%0d t=%b, want v=%b i=%0d t=%b",
                     e.name, gnt_valid, gnt_idx, timeout, e.ev, e.ei, e.et);
        end
    endtask

    initial begin
        // reset then idle
        tbl.push_back(mk(1, 4'b0000, 0, 0, 0, 0, "reset"));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 0, "idle"));
        // ptr=0, req 1010 -> 1, then ptr=2 -> 3
        tbl.push_back(mk(0, 4'b1010, 0, 1, 1, 0, "b_g1"));
        tbl.push_back(mk(0, 4'b1010, 1, 0, 1, 0, "b_rel1"));
        tbl.push_back(mk(0, 4'b1010, 0, 1, 3, 0, "b_g3"));
        tbl.push_back(mk(0, 4'b1010, 1, 0, 3, 0, "b_rel3"));
        // req 1111, done on second grant cycle -> 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(mk(0, 4'b1111, 0, 1, 2'(k), 0, "c_grant"));
            tbl.push_back(mk(0, 4'b1111, 0, 1, 2'(k), 0, "c_hold"));
            tbl.push_back(mk(0, 4'b1111, 1, 0, 2'(k), 0, "c_rel"));
        end
        // ptr=1, req 0100 held: 4 cycles then timeout
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 0, "d_hold"));
        tbl.push_back(mk(0, 4'b0100, 0, 0, 2, 1, "d_timeout"));
        tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 0, "d_regrant"));
        tbl.push_back(mk(0, 4'b0000, 0, 0, 2, 0, "d_reqdrop"));
        // done coincident with limit; other req bits toggle
        tbl.push_back(mk(0, 4'b0100, 0, 1, 2, 0, "e_grant"));
        tbl.push_back(mk(0, 4'b1111, 0, 1, 2, 0, "e_other1"));
        tbl.push_back(mk(0, 4'b0101, 0, 1, 2, 0, "e_other2"));
        tbl.push_back(mk(0, 4'b1100, 0, 1, 2, 0, "e_other3"));
        tbl.push_back(mk(0, 4'b0100, 1, 0, 2, 0, "e_done_lim"));
        tbl.push_back(mk(0, 4'b0000, 1, 0, 2, 0, "e_idle_done"));
        // ptr=3: reset during grant to 3
        tbl.push_back(mk(0, 4'b1000, 0, 1, 3, 0, "f_grant3"));
        tbl.push_back(mk(0, 4'b1000, 0, 1, 3, 0, "f_hold3"));
        tbl.push_back(mk(1, 4'b1000, 0, 0, 0, 0, "f_reset"));
        tbl.push_back(mk(0, 4'b1001, 0, 1, 0, 0, "f_grant0"));
        tbl.push_back(mk(0, 4'b1001, 1, 0, 0, 0, "f_rel0"));

        foreach (tbl[i]) step(tbl[i]);

        // all requesting, no done: every grant times out, ptr from 1
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++)
                step(mk(0, 4'b1111, 0, 1, 2'((1 + g) % 4), 0, "g_hold"));
            step(mk(0, 4'b1111, 0, 0, 2'((1 + g) % 4), 1, "g_timeout"));
        end

        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard: got %0d left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rr_arb4_idx.md
Name: rr_arb4_idx

Overview:
Four-requester round-robin arbiter that produces a registered 2-bit grant index plus valid, for sharing one resource among four clients. gnt_idx feeds decode2to4 directly, which turns it into a one-hot grant vector; gnt_valid gates that vector downstream. A grant is held until the owner signals done, drops its request, or exceeds a hold-time limit.

Parameters:
MAX_HOLD, 16, maximum cycles a grant may be held before forced release; legal range >= 2.
CNT_W, $clog2(MAX_HOLD+1), width of the hold counter; derived, do not override.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  4  request vector, bit i = client i requesting
done  input  1  current owner finished; releases grant
gnt_idx  output  2  registered index of granted client
gnt_valid  output  1  registered; gnt_idx is a live grant
timeout  output  1  one-cycle pulse when grant was force-released by MAX_HOLD

Behaviour:
- All state updates on rising clk; reset is sampled only at clk, not asynchronously.
- Reset values: state=IDLE, gnt_valid=0, gnt_idx=0, timeout=0, ptr=0, hold_cnt=0.
- Reset mid-grant: next edge forces the reset values; no timeout pulse is generated.
- ptr (2 bits) = highest-priority client. Search order: ptr, ptr+1, ptr+2, ptr+3, all mod 4 (wraps 3->0).
- FSM states: IDLE, GRANT.
- IDLE, req==0: remain in IDLE with gnt_valid=0.
- IDLE, req!=0: go to GRANT. gnt_idx=winner, gnt_valid=1, hold_cnt=0, all on the next edge.
- Latency: 1 cycle from the edge where req is sampled to gnt_valid high.
- GRANT, no release: hold_cnt increments by 1 each cycle.
- GRANT, release when any of the following holds:
  - (a) done=1
  - (b) req[gnt_idx]=0
  - (c) hold_cnt==MAX_HOLD-1
- On release, next edge: state=IDLE, gnt_valid=0, ptr=gnt_idx+1 mod 4, hold_cnt=0.
- timeout=1 for exactly that one cycle if the release cause was (c) alone.
- Simultaneous release causes: done or req drop together with (c) counts as a normal release, timeout=0.
- A grant therefore lasts at most MAX_HOLD cycles.
- After every release there is one mandatory IDLE cycle with gnt_valid=0 before the next grant. This guarantees a clean one-hot handover downstream.
- gnt_idx holds its last value while gnt_valid=0. Downstream must qualify with gnt_valid.
- Changes on req bits other than req[gnt_idx] during GRANT are ignored.
- done asserted while in IDLE is ignored.
- timeout is 0 in every cycle except the forced-release cycle.
- Starvation bound: any continuously asserted request is granted within 3 grant periods plus 4 idle cycles.

Decomposition:
- Shared package arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - localparam NUM_REQ=4
  - typedef logic [1:0] idx_t
- One combinational sub-module, rr_pick4:
  - inputs req[3:0] and ptr[1:0]
  - outputs any and win_idx[1:0]
  - implements the rotated priority search
- rr_arb4_idx contains the FSM, hold counter, ptr register and output registers.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt_valid=0, timeout=0, gnt_idx=0 throughout.
- ptr=0, req=4'b1010 -> gnt_idx=1, gnt_valid=1 one cycle later. Then done pulse -> gnt_valid=0 next cycle, ptr=2. Next grant is gnt_idx=3.
- req=4'b1111 held, done pulsed on cycle 2 of each grant -> grant sequence 0,1,2,3,0 with exactly one gnt_valid=0 cycle between consecutive grants.
- MAX_HOLD=4, req=4'b0100 held, done=0 -> gnt_valid high exactly 4 cycles. timeout=1 for one cycle coincident with gnt_valid falling, then regrant to idx 2 after the idle cycle.
- MAX_HOLD=4, done=1 on the 4th grant cycle -> release with timeout=0. Separately, owner drops req mid-grant -> release next edge with timeout=0.
- reset asserted on cycle 2 of a grant to idx 3 -> next edge gnt_valid=0, gnt_idx=0, ptr=0. Then req=4'b1001 -> grant idx 0.
